// File: rtl/ram_rd_stream_if.sv
// Command and output-stream bundle for ram_rd_stream.
// The master drives commands and consumes beats. The slave is the controller.
interface ram_rd_stream_if #(
    parameter int DW = 32,
    parameter int AW = 9
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output cmd_valid, cmd_base, cmd_len, out_ready,
        input  cmd_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, out_ready,
        output cmd_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ram_rd_stream.sv
// Burst read controller for a registered-output buffer, feeding a credit-protected skid FIFO.
// Optional stall counter port stall_cnt is enabled by defining RAM_RD_STREAM_PERF_EN.
module ram_rd_stream #(
    parameter int DW         = 32,
    parameter int AW         = 9,
    parameter int DEPTH      = 512,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    ram_rd_stream_if.slave bus,
    output logic [AW-1:0]  ram_rd_addr,
    input  logic [DW-1:0]  ram_rd_data,
    output logic           busy
`ifdef RAM_RD_STREAM_PERF_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + RD_LATENCY + 1);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_reg;
    logic [AW-1:0]         addr_reg;
    logic [AW:0]           remaining_reg;
    logic                  cmd_ready_reg;
    logic                  busy_reg;

    logic [RD_LATENCY-1:0] tag_valid_reg, tag_valid_next;
    logic [RD_LATENCY-1:0] tag_last_reg, tag_last_next;

    logic [DW-1:0]         fifo_data_reg [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] fifo_last_reg;
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         fifo_count_reg;

    logic [CW-1:0]         inflight;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  head_last;
    logic [AW-1:0]         addr_next;

    // Credits use registered counts only, so a pop in this cycle frees a slot next cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(tag_valid_reg[i]);
        end
        credit_ok = (inflight + fifo_count_reg) < CW'(SKID_DEPTH);
        issue     = (state_reg == ISSUE) && (remaining_reg != '0) && credit_ok;
        push      = tag_valid_reg[RD_LATENCY-1];
        pop       = (fifo_count_reg != '0) && bus.out_ready;
        head_last = fifo_last_reg[rd_ptr_reg];
        addr_next = (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_reg && (bus.cmd_len != '0)) begin
                        addr_reg      <= bus.cmd_base;
                        remaining_reg <= bus.cmd_len;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_reg      <= addr_next;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == LEN_ONE) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag pipeline tracks the buffer's read latency; the last stage marks valid rd_data.
    assign tag_valid_next[0] = issue;
    assign tag_last_next[0]  = issue && (remaining_reg == LEN_ONE);
    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_tag
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_last_next[gi]  = tag_last_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_last_reg  <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_last_reg  <= tag_last_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_reg[wr_ptr_reg] <= ram_rd_data;
            fifo_last_reg[wr_ptr_reg] <= tag_last_reg[RD_LATENCY-1];
        end
    end

    assign ram_rd_addr   = addr_reg;
    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.out_valid = (fifo_count_reg != '0);
    assign bus.out_data  = fifo_data_reg[rd_ptr_reg];
    assign bus.out_last  = (fifo_count_reg != '0) && head_last;
    assign busy          = busy_reg && !(pop && head_last);

`ifdef RAM_RD_STREAM_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic        stall_now;

    assign stall_now = ((state_reg == ISSUE) && (remaining_reg != '0) && !credit_ok)
                     || ((fifo_count_reg != '0) && !bus.out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_now && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_ram_rd_stream.sv
// Self-checking bench for ram_rd_stream: buffer model holds addr*3, scoreboard derived from commands.
// Build with RAM_RD_STREAM_PERF_EN defined to also check stall_cnt.
module tb_ram_rd_stream;
    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int SKID  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          busy;
`ifdef RAM_RD_STREAM_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    ram_rd_stream_if #(.DW(DW), .AW(AW)) bus ();

    ram_rd_stream #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LATENCY(2), .SKID_DEPTH(SKID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .busy(busy)
`ifdef RAM_RD_STREAM_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Buffer model: address register then output register.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ram_addr_q;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);
    always @(posedge clk) begin
        ram_addr_q  <= ram_rd_addr;
        ram_rd_data <= mem[ram_addr_q];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] got_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_last_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: every accepted command expands into its beat list.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (bus.cmd_valid && bus.cmd_ready) begin
            for (int i = 0; i < int'(bus.cmd_len); i++) begin
                exp_q.push_back('{data: DW'(((int'(bus.cmd_base) + i) % DEPTH) * 3),
                                  last: (i == int'(bus.cmd_len) - 1)});
            end
        end
    end

    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         mon_beat;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            chk("fifo_count_bound", 64'(int'(dut.fifo_count_reg) <= SKID), 64'd1);
            if (prev_hold) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", 64'(bus.out_data), 64'(prev_data));
                chk("hold_last", 64'(bus.out_last), 64'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_beat = exp_q.pop_front();
                    chk("beat_data", 64'(bus.out_data), 64'(mon_beat.data));
                    chk("beat_last", 64'(bus.out_last), 64'(mon_beat.last));
                end
                got_q.push_back(bus.out_data);
                if (bus.out_last) n_last_seen++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_last = bus.out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int base, input int len);
        bus.cmd_base  = AW'(base);
        bus.cmd_len   = (AW+1)'(len);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        chk("cmd_ready_at_send", 64'(bus.cmd_ready), 64'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int pct, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            bus.out_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (!busy && bus.cmd_ready && !bus.out_valid && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk("idle_within_bound", 64'(done), 64'd1);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Stall reference from the credit and stream rules; cycle 0 is the handshake cycle.
    function automatic int model_stall(input int len, input int hold);
        int iss[$];
        int npop;
        int stalls;
        int infl;
        int fifo;
        bit blocked;
        bit rdy;
        npop = 0;
        stalls = 0;
        for (int c = 1; c < 100; c++) begin
            infl = 0;
            fifo = 0;
            rdy = (c > hold);
            foreach (iss[i]) begin
                if (iss[i] >= c - 2 && iss[i] <= c - 1) infl++;
                if (iss[i] + 3 <= c && i >= npop) fifo++;
            end
            blocked = (iss.size() < len) && (infl + fifo >= SKID);
            if (iss.size() < len && !blocked) iss.push_back(c);
            if (blocked || (fifo > 0 && !rdy)) stalls++;
            if (fifo > 0 && rdy) npop++;
        end
        return stalls;
    endfunction

    typedef struct {
        int            base;
        int            len;
        int            pct;
        int            exp_beats;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_final;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lastn;
        int exp_stall;
        vecs[0] = '{10,  4,   100, 4,   32'd30,   32'd39};
        vecs[1] = '{510, 4,   50,  4,   32'd1530, 32'd3};
        vecs[2] = '{0,   1,   50,  1,   32'd0,    32'd0};
        vecs[3] = '{500, 20,  50,  20,  32'd1500, 32'd21};
        vecs[4] = '{0,   512, 70,  512, 32'd0,    32'd1533};
        vecs[5] = '{300, 9,   25,  9,   32'd900,  32'd924};
        vecs[6] = '{511, 2,   100, 2,   32'd1533, 32'd0};

        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
`ifdef RAM_RD_STREAM_PERF_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_first_cycle", 64'(bus.cmd_ready), 64'd0);
        step();
        @(negedge clk);
        chk("cmd_ready_second_cycle", 64'(bus.cmd_ready), 64'd1);
        step();

        // Cycle-exact latency of a short burst with the consumer always ready.
        got_q.delete();
        bus.cmd_base  = 9'd10;
        bus.cmd_len   = 10'd4;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) chk("t1_rd_addr", 64'(ram_rd_addr), 64'(10 + k - 1));
            chk("t1_out_valid", 64'(bus.out_valid), 64'(k >= 4 && k <= 7));
            if (k >= 4 && k <= 7) chk("t1_out_data", 64'(bus.out_data), 64'(30 + 3 * (k - 4)));
            chk("t1_out_last", 64'(bus.out_last), 64'(k == 7));
            chk("t1_busy", 64'(busy), 64'(k >= 1 && k <= 6));
            chk("t1_cmd_ready", 64'(bus.cmd_ready), 64'(k == 0 || k == 8));
            step();
            if (k == 0) bus.cmd_valid = 1'b0;
        end

        // Backpressure: consumer stalled 12 cycles, data must hold then drain intact.
        got_q.delete();
        bus.out_ready = 1'b0;
        send_cmd(10, 4);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
                chk("t2_out_data", 64'(bus.out_data), 64'd30);
            end
            if (k >= 5) chk("t2_addr_hold", 64'(ram_rd_addr), 64'd14);
            step();
        end
        wait_idle(100, 50);
        chk("t2_beats", 64'(got_q.size()), 64'd4);

        // Address wrap at the top of the buffer.
        got_q.delete();
        bus.out_ready = 1'b1;
        send_cmd(510, 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t3_rd_addr", 64'(ram_rd_addr), 64'((510 + k - 1) % DEPTH));
            step();
        end
        wait_idle(100, 50);
        chk("t3_beats", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            chk("t3_data2", 64'(got_q[2]), 64'd0);
            chk("t3_data3", 64'(got_q[3]), 64'd3);
        end

        // Zero-length command is accepted and produces nothing.
        send_cmd(5, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_cmd_ready", 64'(bus.cmd_ready), 64'd1);
            chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
            chk("t4_busy", 64'(busy), 64'd0);
            step();
        end
        got_q.delete();
        lastn = n_last_seen;
        send_cmd(5, 1);
        wait_idle(100, 50);
        chk("t4_len1_beats", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) chk("t4_len1_data", 64'(got_q[0]), 64'd15);
        chk("t4_len1_last", 64'(n_last_seen - lastn), 64'd1);

        // Reset in the middle of a long burst.
        send_cmd(0, 64);
        for (int k = 0; k < 20; k++) begin
            bus.out_ready = ($urandom_range(99) < 50);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_out_valid_after_rst", 64'(bus.out_valid), 64'd0);
        chk("t5_busy_after_rst", 64'(busy), 64'd0);
        chk("t5_cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t5_no_stale_beat", 64'(bus.out_valid), 64'd0);
            step();
        end
        got_q.delete();
        send_cmd(0, 2);
        wait_idle(100, 50);
        chk("t5_beats", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("t5_data0", 64'(got_q[0]), 64'd0);
            chk("t5_data1", 64'(got_q[1]), 64'd3);
        end

        // Table of bursts under random backpressure.
        for (int v = 0; v < 7; v++) begin
            got_q.delete();
            lastn = n_last_seen;
            bus.out_ready = ($urandom_range(99) < vecs[v].pct);
            send_cmd(vecs[v].base, vecs[v].len);
            wait_idle(vecs[v].pct, vecs[v].len * 8 + 100);
            chk("vec_beats", 64'(got_q.size()), 64'(vecs[v].exp_beats));
            if (got_q.size() != 0) begin
                chk("vec_first", 64'(got_q[0]), 64'(vecs[v].exp_first));
                chk("vec_final", 64'(got_q[got_q.size() - 1]), 64'(vecs[v].exp_final));
            end
            chk("vec_one_last", 64'(n_last_seen - lastn), 64'd1);
        end

        // Credit stall: 8 words, consumer stalled through cycle 10 after the handshake.
        do_reset();
`ifdef RAM_RD_STREAM_PERF_EN
        @(negedge clk);
        chk("perf_cnt_after_rst", 64'(stall_cnt), 64'd0);
        step();
`endif
        got_q.delete();
        bus.out_ready = 1'b0;
        send_cmd(10, 8);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) chk("t6_credit_addr_hold", 64'(ram_rd_addr), 64'd14);
            step();
        end
        bus.out_ready = 1'b1;
        wait_idle(100, 100);
        chk("t6_beats", 64'(got_q.size()), 64'd8);
        exp_stall = model_stall(8, 10);
`ifdef RAM_RD_STREAM_PERF_EN
        @(negedge clk);
        chk("perf_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        step();
        do_reset();
        @(negedge clk);
        chk("perf_cnt_cleared", 64'(stall_cnt), 64'd0);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ram_rd_stream.md
Name: ram_rd_stream

Overview:
- Read-side controller placed directly downstream of an M20K dual-port buffer with registered output.
- Accepts a burst command (base address, length) and drives the buffer's read address one word per cycle.
- Captures returned words in a small skid FIFO and presents them as a valid/ready stream to the consuming datapath, with full backpressure and no data loss.
- Credit-based issue guarantees every in-flight read has a FIFO slot reserved.

Parameters:
- DW, 32, data word width; matches the buffer width.
- AW, 9, buffer address width.
- DEPTH, 512, buffer words; addresses wrap DEPTH-1 -> 0 and need not be a power of two.
- RD_LATENCY, 2, cycles from rd_addr driven to rd_data valid; 2 for address plus output register.
- SKID_DEPTH, 4, FIFO entries; power of two; must be >= RD_LATENCY+2 for full throughput.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_base  in  AW  first buffer address.
- cmd_len  in  AW+1  number of words, 0..DEPTH.
- ram_rd_addr  out  AW  to buffer rd_addr.
- ram_rd_data  in  DW  from buffer rd_data.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  DW  beat data.
- out_last  out  1  final beat of burst.
- busy  out  1  high from command accept until the last beat is popped.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cmd_ready=0, then 1 the cycle after rst deasserts. out_valid=0, out_last=0, busy=0, ram_rd_addr=0, FIFO empty, in-flight pipeline cleared, state IDLE.
- FSM IDLE:
  - cmd_ready=1.
  - On handshake with cmd_len>0: latch addr=cmd_base, remaining=cmd_len, go to ISSUE, busy=1.
  - On handshake with cmd_len=0: stay in IDLE, no beats, busy stays 0.
- FSM ISSUE:
  - cmd_ready=0.
  - Issue one read per cycle when credits allow: inflight + fifo_count < SKID_DEPTH. Counts are registered; a same-cycle pop is not credited.
  - On issue: ram_rd_addr=addr. Next addr = (addr==DEPTH-1) ? 0 : addr+1. remaining decrements.
  - The issue of the final word sets that word's tag last=1. Then go to DRAIN.
- FSM DRAIN:
  - No issue.
  - Return to IDLE on the cycle the last-tagged beat is popped. busy drops that same cycle and cmd_ready rises the next cycle.
- In-flight tracking:
  - RD_LATENCY-deep shift register of {valid, last} tags.
  - When a tag exits, ram_rd_data is written to the FIFO together with its last tag.
  - inflight = popcount of valid tags.
- FIFO output is registered: out_data/out_last come from the head entry, and out_valid = !empty. Pop occurs when out_valid && out_ready.
- Latency, with out_ready=1 and defaults: handshake at cycle T. First rd_addr at T+1, data at T+3, out_valid at T+4. Then one beat per cycle.
- Stream rules:
  - out_data and out_last hold stable while out_valid=1 && out_ready=0.
  - out_last=1 on exactly one beat per nonzero burst.
- Simultaneous FIFO write and pop: both take effect. Count is unchanged and data order is preserved.
- FIFO overflow is impossible by construction. The bench asserts count <= SKID_DEPTH.
- cmd_len=DEPTH: every address is read once, wrapping as needed.
- rst mid-burst: all state is cleared in the next cycle. RAM returns still in the buffer pipeline are discarded because the tags were cleared. No out_valid is asserted until a new command is accepted.

Optional Feature:
- Macro RAM_RD_STREAM_PERF_EN.
- Defined: adds output port stall_cnt (32 bits), reset to 0.
  - Increments (saturating) each cycle in ISSUE where remaining>0 and credits block issue.
  - Also increments each cycle where out_valid=1 and out_ready=0.
  - Both conditions in one cycle: +1.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Buffer preloaded addr[i]=i*3. Command base=10, len=4, out_ready=1, handshake at T -> beats 30,33,36,39 at T+4..T+7. out_last only at T+7. busy falls at T+7. cmd_ready=1 at T+8.
- Same command with out_ready=0 for 12 cycles after the handshake -> exactly 4 reads issued, then ram_rd_addr holds with no further issue. out_valid=1 holding 30. Release -> 30,33,36,39 with no loss or duplicates.
- base=510, len=4, DEPTH=512 -> ram_rd_addr sequence 510,511,0,1. Data returned in that order.
- cmd_len=0 -> cmd_ready stays 1. No out_valid or busy for 10 cycles. A following len=1 command at base 5 returns 15 with out_last=1.
- len=64, random out_ready at 50%, rst pulsed for 1 cycle mid-burst -> out_valid=0 and busy=0 the cycle after reset. No stale beat appears. The next command (base 0, len 2) returns 0,3.
- With RAM_RD_STREAM_PERF_EN, len=8 and out_ready=0 for 10 cycles -> stall_cnt increments by the blocked cycles; the exact value is checked against the bench's reference model. rst -> stall_cnt=0.
